// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and helpers for the branch predictor
//
// Purpose : 2-bit BHT state encoding, branch opcode and reset state.
// Ports   : none (package).

package branch_predictor_pkg;

    // 2-bit saturating counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Opcode bits [6:2] of a conditional branch (BRANCH major opcode).
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    // Every BHT entry starts weakly not-taken so a single taken outcome flips it.
    localparam bht_state_e BHT_RST_VAL = WNT;

    function automatic logic pred_of(input logic [1:0] cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// rtl/branch_predictor_sat_ctr2.sv - 2-bit saturating up/down counter update function
//
// Purpose : next-state function for one BHT entry.
// Ports   : cnt_i  current 2-bit state
//           inc_i  1 = branch taken (count up), 0 = not taken (count down)
//           cnt_o  next state, saturating at 00 and 11

module sat_ctr2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != ST) begin
                cnt_o = cnt_i + 2'd1;
            end
        end else begin
            if (cnt_i != SNT) begin
                cnt_o = cnt_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal branch predictor with EX-stage misprediction recovery
//
// Purpose : IF-stage lookup of a tagless 2-bit counter BHT, EX-stage update,
//           redirect/flush generation and a saturating misprediction counter.
// Ports   : clk, rst               clock, synchronous active-high reset
//           if_pc, if_pred_taken   fetch lookup (combinational)
//           ex_valid, ex_op_code,
//           ex_pc, ex_pred_taken,
//           ex_taken, ex_target    resolved branch from the branch unit
//           mispredict, flush,
//           redirect_pc            same-cycle fetch steering
//           mispredict_count       saturating statistics counter

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [4:0]       ex_op_code,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int               DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       bht_q [DEPTH];
    logic [1:0]       bht_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             br_ev;
    logic [1:0]       ex_cur;
    logic [1:0]       ex_upd;

    // The byte offset and the high PC bits do not select an entry (no tag).
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Reads the registered table only: a same-cycle update of this index is
    // not forwarded, the new value appears after the edge.
    assign if_pred_taken = pred_of(bht_q[if_idx]);

    // Gating with rst discards any branch sitting in EX during reset.
    assign br_ev  = ex_valid & (ex_op_code == OP_BRANCH) & ~rst;
    assign ex_cur = bht_q[ex_idx];

    sat_ctr2 u_sat_ctr2 (
        .cnt_i (ex_cur),
        .inc_i (ex_taken),
        .cnt_o (ex_upd)
    );

    always_comb begin
        mispredict  = br_ev & (ex_taken != ex_pred_taken);
        flush       = mispredict;
        // Wraps modulo 2^32, so 0xFFFFFFFC + 4 redirects to 0.
        redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    end

    always_comb begin
        bht_d = bht_q;
        if (br_ev) begin
            bht_d[ex_idx] = ex_upd;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign mispredict_count = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= BHT_RST_VAL;
            end
            cnt_q <= '0;
        end else begin
            bht_q <= bht_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - table-driven scoreboard bench for branch_predictor

module tb_branch_predictor;

    localparam int CNT_W = 4;
    localparam logic [4:0] BR  = 5'b11000;
    localparam logic [4:0] ALU = 5'b01100;
    localparam logic [4:0] JLR = 5'b11001;

    typedef struct {
        string            tag;
        logic             rst;
        logic [31:0]      if_pc;
        logic             ex_valid;
        logic [4:0]       op;
        logic [31:0]      ex_pc;
        logic             pred;
        logic             taken;
        logic [31:0]      tgt;
        logic             e_if;
        logic             e_mis;
        logic [31:0]      e_rpc;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic [4:0]       ex_op_code;
    logic [31:0]      ex_pc;
    logic             ex_pred_taken;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] mispredict_count;

    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    vec_t sb[$];

    branch_predictor #(.IDX_W(4), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_op_code       (ex_op_code),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic gen(input string tag, input logic r, input logic [31:0] ipc,
                       input logic v, input logic [4:0] op, input logic [31:0] epc,
                       input logic p, input logic t, input logic [31:0] tg,
                       input logic e_if, input logic e_mis, input logic [31:0] e_rpc,
                       input logic [CNT_W-1:0] e_cnt);
        vec_t x;
        x.tag = tag; x.rst = r; x.if_pc = ipc; x.ex_valid = v; x.op = op;
        x.ex_pc = epc; x.pred = p; x.taken = t; x.tgt = tg;
        x.e_if = e_if; x.e_mis = e_mis; x.e_rpc = e_rpc; x.e_cnt = e_cnt;
        vecs.push_back(x);
    endtask

    task automatic br(input string tag, input logic [31:0] ipc, input logic [31:0] epc,
                      input logic p, input logic t, input logic [31:0] tg,
                      input logic e_if, input logic e_mis, input logic [31:0] e_rpc,
                      input logic [CNT_W-1:0] e_cnt);
        gen(tag, 1'b0, ipc, 1'b1, BR, epc, p, t, tg, e_if, e_mis, e_rpc, e_cnt);
    endtask

    task automatic bub(input string tag, input logic [31:0] ipc, input logic e_if,
                       input logic [CNT_W-1:0] e_cnt);
        gen(tag, 1'b0, ipc, 1'b0, BR, 32'h0, 1'b1, 1'b0, 32'h0, e_if, 1'b0, 32'h0, e_cnt);
    endtask

    task automatic check(input vec_t v);
        n_vec++;
        if (mispredict !== v.e_mis) begin
            n_fail++;
            $display("FAIL %s mispredict got %0b want %0b", v.tag, mispredict, v.e_mis);
        end
        if (flush !== v.e_mis) begin
            n_fail++;
            $display("FAIL %s flush got %0b want %0b", v.tag, flush, v.e_mis);
        end
        if (if_pred_taken !== v.e_if) begin
            n_fail++;
            $display("FAIL %s if_pred_taken got %0b want %0b", v.tag, if_pred_taken, v.e_if);
        end
        if (mispredict_count !== v.e_cnt) begin
            n_fail++;
            $display("FAIL %s mispredict_count got %0d want %0d", v.tag, mispredict_count, v.e_cnt);
        end
        if (v.e_mis && (redirect_pc !== v.e_rpc)) begin
            n_fail++;
            $display("FAIL %s redirect_pc got %08h want %08h", v.tag, redirect_pc, v.e_rpc);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit later, update on the next rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst           = v.rst;
        if_pc         = v.if_pc;
        ex_valid      = v.ex_valid;
        ex_op_code    = v.op;
        ex_pc         = v.ex_pc;
        ex_pred_taken = v.pred;
        ex_taken      = v.taken;
        ex_target     = v.tgt;
        sb.push_back(v);
        #1;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard empty");
        end else begin
            check(sb.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b1; ex_op_code = BR;
        ex_pc = 32'h40; ex_pred_taken = 1'b0; ex_taken = 1'b1; ex_target = 32'h100;

        // Two reset cycles with a mispredicting branch in EX.
        gen("rst_hold0", 1'b1, 32'h0, 1'b1, BR, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'd0);
        gen("rst_hold1", 1'b1, 32'h0, 1'b1, BR, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'd0);
        for (int i = 0; i < 16; i++) bub("reset_sweep", 32'(i * 4), 1'b0, 4'd0);

        // Training at 0x40 (index 0); same-cycle lookup sees the old value.
        br ("train1",   32'h40, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 4'd0);
        br ("train2",   32'h40, 32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 4'd1);
        bub("train_chk", 32'h40, 1'b1, 4'd2);

        // Saturation at 0x8 (index 2).
        br ("sat_t1",  32'h8, 32'h8, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   4'd2);
        br ("sat_t2",  32'h8, 32'h8, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   4'd2);
        br ("sat_t3",  32'h8, 32'h8, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   4'd2);
        br ("sat_t4",  32'h8, 32'h8, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   4'd2);
        br ("sat_t5",  32'h8, 32'h8, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   4'd2);
        br ("sat_n1",  32'h8, 32'h8, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'hC,   4'd2);
        bub("sat_wt",  32'h8, 1'b1, 4'd3);
        br ("sat_n2",  32'h8, 32'h8, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0,   4'd3);
        br ("sat_n3",  32'h8, 32'h8, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,   4'd3);
        br ("sat_n4",  32'h8, 32'h8, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0,   4'd3);
        bub("sat_snt", 32'h8, 1'b0, 4'd3);
        br ("sat_up",  32'h8, 32'h8, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 4'd3);
        bub("sat_chk", 32'h8, 1'b0, 4'd4);

        // Not-taken mispredict with PC wrap (index 15).
        br ("wrap_nt",  32'h3C, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234, 1'b0, 1'b1, 32'h0, 4'd4);
        bub("wrap_chk", 32'h3C, 1'b0, 4'd5);

        // Qualifier: non-branch opcodes and invalid slots change nothing.
        gen("qual_alu",  1'b0, 32'hC, 1'b1, ALU, 32'hC, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 4'd5);
        gen("qual_inv",  1'b0, 32'hC, 1'b0, BR,  32'hC, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 4'd5);
        gen("qual_jalr", 1'b0, 32'hC, 1'b1, JLR, 32'hC, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 4'd5);
        bub("qual_chk",  32'hC, 1'b0, 4'd5);

        // Aliasing: 0x4C shares index 3 with 0xC.
        br ("alias_upd", 32'hC, 32'h4C, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 4'd5);
        bub("alias_chk", 32'hC, 1'b1, 4'd5);

        foreach (vecs[i]) apply(vecs[i]);

        // Statistics counter saturates at all-ones.
        for (int k = 0; k < 12; k++) begin
            vec_t x;
            x.tag = "cnt_sat"; x.rst = 1'b0; x.if_pc = 32'h0; x.ex_valid = 1'b1;
            x.op = BR; x.ex_pc = 32'h80; x.pred = 1'b0; x.taken = 1'b1; x.tgt = 32'h500;
            x.e_if = 1'b1; x.e_mis = 1'b1; x.e_rpc = 32'h500;
            x.e_cnt = CNT_W'((5 + k > 15) ? 15 : 5 + k);
            apply(x);
        end

        // Reset mid-run with a mispredicting branch at 0x8 in EX.
        vecs.delete();
        gen("midrst0", 1'b1, 32'h40, 1'b1, BR, 32'h8, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 4'd15);
        gen("midrst1", 1'b1, 32'h40, 1'b1, BR, 32'h8, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 4'd0);
        for (int i = 0; i < 16; i++) bub("midrst_sweep", 32'(i * 4), 1'b0, 4'd0);
        br ("resume",     32'h8, 32'h8, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 4'd0);
        bub("resume_chk", 32'h8, 1'b1, 4'd1);
        foreach (vecs[i]) apply(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and misprediction-recovery unit for the pipelined RISC-V core. In IF it looks up a 2-bit saturating-counter branch history table (BHT) indexed by the fetch PC and returns a taken/not-taken prediction. In EX it takes the resolved outcome from the branch unit, compares it with the prediction carried down the pipeline, updates the BHT, and drives the redirect and flush signals that steer fetch. It also keeps a saturating misprediction counter for performance debug.

## Interface
Parameters:
- IDX_W, 4: BHT index width; the table has 2^IDX_W entries.
- CNT_W, 16: width of the misprediction statistics counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- if_pc  input  32  fetch PC; index = if_pc[IDX_W+1:2].
- if_pred_taken  output  1  prediction for if_pc = MSB of the indexed counter.
- ex_valid  input  1  EX stage holds a valid, non-bubbled instruction.
- ex_op_code  input  5  opcode bits [6:2] of the EX instruction; a branch when equal to 5'b11000.
- ex_pc  input  32  PC of the EX instruction.
- ex_pred_taken  input  1  prediction that travelled with the instruction from IF.
- ex_taken  input  1  resolved outcome (Branch) from the branch unit.
- ex_target  input  32  computed branch target.
- mispredict  output  1  EX branch outcome differs from its prediction.
- redirect_pc  output  32  correct next PC when mispredict=1: ex_target if ex_taken=1, else ex_pc+4.
- flush  output  1  squash the IF/ID and ID/EX registers; equals mispredict.
- mispredict_count  output  CNT_W  number of mispredictions since reset, saturating.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is bit 1.
- Branch qualifier: br_ev = ex_valid & (ex_op_code==5'b11000) & ~rst.
- When br_ev=1, the entry at ex_pc[IDX_W+1:2] updates at the edge: ex_taken=1 increments it, saturating at 11; ex_taken=0 decrements it, saturating at 00.
- Non-branch or invalid EX instructions update nothing and never assert mispredict.
- mispredict = br_ev & (ex_taken != ex_pred_taken). flush = mispredict.
- When mispredict=0, redirect_pc is still driven by the same mux, but it is a don't-care for the consumer.
- mispredict_count increments by 1 at each edge where mispredict=1. It holds at all-ones.
- Address arithmetic is 32-bit modulo: ex_pc+4 wraps from 0xFFFFFFFC to 0x0.
- Aliasing is accepted: the BHT has no tag. PCs that share index bits share a counter.

## Timing
- if_pred_taken is combinational from if_pc and the current BHT state, with zero latency.
- mispredict, flush and redirect_pc are combinational from the EX inputs. The fetch mux uses them in the same cycle, so the next-edge PC is redirect_pc.
- BHT writes become visible one cycle after the update edge.
- Same-cycle read and write of the same index: if_pred_taken returns the old (pre-update) value. There is no bypass.
- Reset, on an edge with rst=1:
  - every BHT entry is set to 01;
  - mispredict_count is set to 0.
- While rst=1:
  - mispredict and flush are 0;
  - if_pred_taken reads 01 → 0 from the cycle after the first reset edge.
- Reset mid-operation: a branch present in EX during rst is discarded and causes no update. Normal operation resumes on the first edge with rst=0.
- The block has no stall input. The pipeline holds ex_valid=0 on bubbles, so no double update can occur.

## Structure
- Shared package (core defines): BHT state constants SNT/WNT/WT/ST, the branch opcode 5'b11000, and the reset value WNT.
- One sub-module, sat_ctr2: a 2-bit saturating up/down update function. The BHT array of 2^IDX_W × 2-bit registers and the stats counter live in the top module.

## Test plan
- Reset: pulse rst for 2 cycles, then sweep if_pc over 0x00–0x3C → if_pred_taken=0 for every entry; mispredict_count=0.
- Training: branch at ex_pc=0x40 resolved taken 2 times with ex_pred_taken=0.
  - 1st resolution: mispredict=1, redirect_pc=ex_target=0x100.
  - Then if_pc=0x40 → if_pred_taken=1.
  - mispredict_count=2.
- Saturation: 5 taken updates at ex_pc=0x8 then one not-taken → entry is 10, if_pred_taken=1. 2 more not-taken → 00.
- Not-taken mispredict: ex_pc=0xFFFFFFFC, ex_pred_taken=1, ex_taken=0 → mispredict=flush=1, redirect_pc=0x0.
- Qualifier and bypass:
  - ex_op_code=5'b01100, or ex_valid=0, with mismatched taken/pred → no mispredict and no BHT change.
  - Same-cycle update and lookup of the same index → old prediction returned, new one visible next cycle.
- Reset mid-run: assert rst while a mispredicting branch is in EX → mispredict=0, count reset to 0, all entries 01.
